// File: rtl/x2821_pkg.sv
// x2821_pkg: shared status-byte layout, counter width and sequencer state encoding.
package x2821_pkg;
    localparam int CNT_W = 5;
    localparam int ST_ATTN = 7;
    localparam int ST_MOD = 6;
    localparam int ST_CUEND = 5;
    localparam int ST_BUSY = 4;
    localparam int ST_CHEND = 3;
    localparam int ST_DVEND = 2;
    localparam int ST_UC = 1;
    localparam int ST_UE = 0;
    localparam logic [7:0] ST_NORMAL = 8'((1 << ST_CHEND) | (1 << ST_DVEND));
    localparam logic [7:0] ST_ABORT = ST_NORMAL | 8'(1 << ST_UC);
    localparam logic [7:0] ST_TIMEOUT = ST_NORMAL | 8'(1 << ST_UE);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, POST} state_t;
endpackage

// File: rtl/pace_timer.sv
// pace_timer: wrap counter 0..period, held at zero while i_zero; ticks at count 0.
module pace_timer #(
    parameter int PACE_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_zero,
    input  logic [PACE_W-1:0] i_period,
    output logic              o_tick
);
    logic [PACE_W-1:0] cnt_q, cnt_d;

    assign cnt_d  = (i_zero || cnt_q == i_period) ? '0 : cnt_q + PACE_W'(1);
    assign o_tick = cnt_q == '0;

    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;
endmodule

// File: rtl/decade_sequencer.sv
// decade_sequencer: clears the decade counter, paces advances up to a target,
// then offers a unit-status byte over a valid/ack handshake.
module decade_sequencer
    import x2821_pkg::*;
#(
    parameter int PACE_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_target,
    input  logic [PACE_W-1:0] i_pace,
    input  logic              i_abort,
    input  logic [CNT_W-1:0]  i_count,
    output logic              o_clear,
    output logic              o_advance,
    output logic              o_busy,
    output logic [7:0]        o_status,
    output logic              o_status_valid,
    input  logic              i_status_ack
);
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   target_q, target_d, prev_q;
    logic [PACE_W-1:0]  pace_q, pace_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [7:0]         status_q, status_d;
    logic               abort_q, clear_q, busy_q, valid_q;
    logic               run, match, tick;

    pace_timer #(.PACE_W(PACE_W)) u_pace (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_zero    (!run),
        .i_period  (pace_q),
        .o_tick    (tick)
    );

    assign run   = state_q == RUN;
    assign match = i_count == target_q;
    // An abort seen during CLEAR suppresses the very first advance.
    assign o_advance      = run && tick && !match && !abort_q;
    assign o_clear        = clear_q;
    assign o_busy         = busy_q;
    assign o_status       = status_q;
    assign o_status_valid = valid_q;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        pace_d   = pace_q;
        status_d = status_q;
        stall_d  = run ? ((i_count != prev_q) ? '0 : stall_q + STALL_W'(1)) : '0;
        case (state_q)
            IDLE:
                if (i_start) begin
                    target_d = i_target;
                    pace_d   = i_pace;
                    state_d  = (i_target == '0) ? POST : CLEAR;
                    status_d = (i_target == '0) ? ST_NORMAL : status_q;
                end
            CLEAR: state_d = RUN;
            RUN:
                if (i_abort || abort_q) begin
                    state_d  = POST;
                    status_d = ST_ABORT;
                end else if (match) begin
                    state_d  = POST;
                    status_d = ST_NORMAL;
                end else if (stall_q == STALL_W'(TIMEOUT)) begin
                    state_d  = POST;
                    status_d = ST_TIMEOUT;
                end
            POST:
                if (i_status_ack) begin
                    state_d  = IDLE;
                    status_d = '0;
                end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            pace_q   <= '0;
            prev_q   <= '0;
            stall_q  <= '0;
            status_q <= '0;
            abort_q  <= 1'b0;
            clear_q  <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            pace_q   <= pace_d;
            prev_q   <= i_count;
            stall_q  <= stall_d;
            status_q <= status_d;
            abort_q  <= (state_q == CLEAR) && i_abort;
            clear_q  <= state_d == CLEAR;
            busy_q   <= state_d != IDLE;
            valid_q  <= state_d == POST;
        end
endmodule

// File: tb/tb_decade_sequencer.sv
// tb_decade_sequencer: directed sequences with a status scoreboard and a decade counter model.
module tb_decade_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [4:0] i_target = '0;
    logic [7:0] i_pace = '0;
    logic       i_abort = 1'b0;
    logic       i_status_ack = 1'b0;
    logic [4:0] cnt = '0;
    logic       frozen = 1'b0;
    logic       o_clear, o_advance, o_busy, o_status_valid, pv = 1'b0;
    logic [7:0] o_status;
    int         cyc = 0, s = 0, vec = 0, miss = 0;

    typedef struct {logic [7:0] st; int cyc;} exp_t;
    exp_t exp_q[$];
    exp_t e;
    int   clr_q[$], adv_q[$];

    decade_sequencer dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_start        (i_start),
        .i_target       (i_target),
        .i_pace         (i_pace),
        .i_abort        (i_abort),
        .i_count        (cnt),
        .o_clear        (o_clear),
        .o_advance      (o_advance),
        .o_busy         (o_busy),
        .o_status       (o_status),
        .o_status_valid (o_status_valid),
        .i_status_ack   (i_status_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (!frozen) begin
            if (o_clear) cnt <= '0;
            else if (o_advance) cnt <= (cnt == 5'd9) ? 5'd0 : cnt + 5'd1;
        end

    task automatic check(input string name, input int act, input int exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (o_clear) clr_q.push_back(cyc);
        if (o_advance) adv_q.push_back(cyc);
        if (o_status_valid && !pv) begin
            if (exp_q.size() == 0) check("unexpected_status", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("status", o_status, e.st);
                check("valid_cycle", cyc, e.cyc);
            end
        end
        pv <= o_status_valid;
    end

    task automatic start_seq(input logic [4:0] tgt, input logic [7:0] pace, input logic [7:0] st,
                             input int rel, input bit push);
        if (push) exp_q.push_back('{st, cyc + 1 + rel});
        clr_q.delete();
        adv_q.delete();
        i_start = 1'b1;
        i_target = tgt;
        i_pace = pace;
        @(negedge clk);
        i_start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 300 && !o_status_valid; i++) @(negedge clk);
        if (!o_status_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic finish_post(input int hold, input bit poke);
        logic [7:0] st0;
        bit ok;
        st0 = o_status;
        ok = 1'b1;
        for (int j = 0; j < hold; j++) begin
            if (poke && j == 3) begin
                i_start = 1'b1;
                i_target = 5'd5;
            end
            @(negedge clk);
            i_start = 1'b0;
            if (!o_status_valid || o_status !== st0) ok = 1'b0;
        end
        if (hold > 0) check("status_stable", ok, 1);
        i_status_ack = 1'b1;
        @(negedge clk);
        i_status_ack = 1'b0;
        check("busy_after_ack", o_busy, 0);
        check("valid_after_ack", o_status_valid, 0);
        check("status_after_ack", o_status, 0);
    endtask

    task automatic check_logs(input int nclr, input int nadv, input int step);
        bit ok;
        ok = 1'b1;
        check("clear_count", clr_q.size(), nclr);
        if (nclr > 0) check("clear_cycle", clr_q[0], s);
        check("adv_count", adv_q.size(), nadv);
        if (nadv > 0) check("adv_first", adv_q[0], s + 1);
        for (int i = 1; i < adv_q.size(); i++) if (adv_q[i] - adv_q[i-1] != step) ok = 1'b0;
        if (nadv > 1) check("adv_spacing", ok, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {o_clear, o_advance, o_busy, o_status_valid, o_status}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        // normal run, ack in the first valid cycle
        start_seq(5'd5, 8'd0, 8'h0C, 7, 1'b1);
        check("busy_k1", o_busy, 1);
        check("clear_k1", o_clear, 1);
        wait_valid();
        finish_post(0, 1'b0);
        check_logs(1, 5, 1);
        // zero target started in the first IDLE cycle after the ack
        start_seq(5'd0, 8'd0, 8'h0C, 0, 1'b1);
        check("zero_no_clear", o_clear, 0);
        wait_valid();
        finish_post(2, 1'b0);
        check_logs(0, 0, 1);
        // paced run with a long ack hold and a start poked during POST
        start_seq(5'd3, 8'd4, 8'h0C, 13, 1'b1);
        wait_valid();
        finish_post(10, 1'b1);
        check_logs(1, 3, 5);
        // stall with a frozen counter
        frozen = 1'b1;
        start_seq(5'd9, 8'd0, 8'h0D, 66, 1'b1);
        wait_valid();
        finish_post(0, 1'b0);
        check_logs(1, 65, 1);
        frozen = 1'b0;
        // abort after two paced advances
        start_seq(5'd9, 8'd4, 8'h0E, 9, 1'b1);
        repeat (8) @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        wait_valid();
        finish_post(0, 1'b0);
        check_logs(1, 2, 5);
        // abort during CLEAR
        start_seq(5'd9, 8'd0, 8'h0E, 2, 1'b1);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        wait_valid();
        finish_post(0, 1'b0);
        check_logs(1, 0, 1);
        // asynchronous reset mid RUN, then restart
        start_seq(5'd9, 8'd0, 8'h00, 0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {o_clear, o_advance, o_busy, o_status_valid, o_status}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_seq(5'd2, 8'd0, 8'h0C, 4, 1'b1);
        wait_valid();
        finish_post(0, 1'b0);
        check_logs(1, 2, 1);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
